// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and types for the demux_stream block.
//               DEMUX_W  - default data width
//               DEMUX_N  - default number of output channels
//               DEMUX_CW - default per-channel transfer counter width
//               DEMUX_SW - select width derived from DEMUX_N
//               slot_state_e - per-channel holding register state
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int DEMUX_W  = 4;
    localparam int DEMUX_N  = 4;
    localparam int DEMUX_CW = 8;
    localparam int DEMUX_SW = $clog2(DEMUX_N);

    // A channel slot is either empty or holding exactly one word.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One output channel of the demultiplexer: a one-entry holding
//               register with valid flag and a wrapping delivered-word counter.
// Ports       : clk     - rising-edge clock
//               rst_n   - synchronous active-low reset
//               load    - write din into the slot this cycle (only asserted
//                         by the top when the slot can take a word)
//               din     - word to store
//               q       - held word
//               q_valid - slot holds a word
//               q_ready - consumer takes the held word this cycle
//               cnt     - number of words delivered, wraps silently
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int W  = DEMUX_W,
    parameter int CW = DEMUX_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  q,
    output logic          q_valid,
    input  logic          q_ready,
    output logic [CW-1:0] cnt
);

    slot_state_e   r_state;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;
    logic          w_drain;

    assign w_drain = (r_state == SLOT_FULL) && q_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_drain) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // A load in the same cycle as a drain refills the slot so the
            // channel streams one word per cycle without a bubble.
            case (r_state)
                SLOT_EMPTY: begin
                    if (load) begin
                        r_data  <= din;
                        r_state <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        r_data  <= din;
                    end else if (w_drain) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase
        end
    end

    assign q       = r_data;
    assign q_valid = (r_state == SLOT_FULL);
    assign cnt     = r_cnt;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_stream
// Description : 1-to-N registered stream demultiplexer. Each accepted input
//               word is steered by sel into a per-channel holding register
//               with its own valid/ready handshake and transfer counter.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               d, sel, d_valid   - input word, destination, producer valid
//               d_ready           - word accepted this cycle
//               q, q_valid        - per-channel data (k at [k*W +: W]), valid
//               q_ready           - per-channel consumer ready
//               cnt               - per-channel delivered count (k at [k*CW +: CW])
//               busy              - any channel holding a word
// Revision    : 1.0 - initial release
// ============================================================================
module demux_stream
    import demux_pkg::*;
#(
    parameter int W  = DEMUX_W,
    parameter int N  = DEMUX_N,
    parameter int SW = $clog2(N),
    parameter int CW = DEMUX_CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    d,
    input  logic [SW-1:0]   sel,
    input  logic            d_valid,
    output logic            d_ready,
    output logic [N*W-1:0]  q,
    output logic [N-1:0]    q_valid,
    input  logic [N-1:0]    q_ready,
    output logic [N*CW-1:0] cnt,
    output logic            busy
);

    logic         w_acc;
    logic [N-1:0] w_load;

    // Only the addressed channel gates acceptance; q_ready reaches d_ready
    // solely through this select mux.
    assign d_ready = rst_n & (~q_valid[sel] | q_ready[sel]);
    assign w_acc   = d_valid & d_ready;

    generate
        for (genvar k = 0; k < N; k++) begin : g_slot
            assign w_load[k] = w_acc && (sel == SW'(k));

            demux_slot #(
                .W  (W),
                .CW (CW)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (w_load[k]),
                .din     (d),
                .q       (q[k*W +: W]),
                .q_valid (q_valid[k]),
                .q_ready (q_ready[k]),
                .cnt     (cnt[k*CW +: CW])
            );
        end
    endgenerate

    // q_valid comes straight from slot registers, so busy has no input path.
    assign busy = |q_valid;

endmodule : demux_stream
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_stream
// Description : Self-checking bench for demux_stream. A per-channel queue
//               scoreboard with wrapping delivery counters models the block;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_stream;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic [W-1:0]    d;
    logic [SW-1:0]   sel;
    logic            d_valid;
    logic            d_ready;
    logic [N*W-1:0]  q;
    logic [N-1:0]    q_valid;
    logic [N-1:0]    q_ready;
    logic [N*CW-1:0] cnt;
    logic            busy;

    demux_stream #(.W(W), .N(N), .SW(SW), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .sel     (sel),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .cnt     (cnt),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting in each channel and words delivered.
    logic [W-1:0]  sbq[N][$];
    logic [CW-1:0] mcnt[N];

    // Monitor: compares DUT outputs to the model every cycle, retires
    // delivered words and records newly accepted ones.
    always @(negedge clk) begin
        logic [N-1:0] exp_v;
        logic         exp_rdy;
        for (int k = 0; k < N; k++) exp_v[k] = (sbq[k].size() != 0);
        exp_rdy = rst_n && (!exp_v[sel] || q_ready[sel]);
        check("q_valid", q_valid, exp_v);
        check("busy", busy, |exp_v);
        check("d_ready", d_ready, exp_rdy);
        for (int k = 0; k < N; k++) begin
            check($sformatf("cnt[%0d]", k), cnt[k*CW +: CW], mcnt[k]);
            if (exp_v[k] && q_ready[k] && rst_n) begin
                check($sformatf("q[%0d]", k), q[k*W +: W], sbq[k][0]);
                void'(sbq[k].pop_front());
                mcnt[k] = mcnt[k] + 1'b1;
            end
        end
        if (rst_n && d_valid && exp_rdy) sbq[sel].push_back(d);
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                sbq[k].delete();
                mcnt[k] = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) mcnt[k] = '0;
        rst_n   = 1'b0;
        d_valid = 1'b1;
        d       = 4'hF;
        sel     = 2'b01;
        q_ready = 4'hF;

        // Reset held two cycles with a word offered.
        repeat (2) tick();
        @(negedge clk);
        check("rst d_ready", d_ready, 1'b0);
        check("rst q_valid", q_valid, 4'b0000);
        check("rst cnt", cnt, 32'h0);
        check("rst busy", busy, 1'b0);
        check("rst q", q, 16'h0);
        tick();
        rst_n   = 1'b1;
        d_valid = 1'b0;
        q_ready = 4'b0000;
        tick();

        // Single route to channel 2.
        d = 4'b0011; sel = 2'b10; d_valid = 1'b1; q_ready = 4'b0100;
        tick();
        d_valid = 1'b0;
        @(negedge clk);
        check("route q_valid", q_valid, 4'b0100);
        check("route q[2]", q[11:8], 4'b0011);
        tick();
        @(negedge clk);
        check("route drained", q_valid, 4'b0000);
        check("route cnt[2]", cnt[23:16], 8'd1);

        // Backpressure on channel 1.
        tick();
        q_ready = 4'b0000;
        d = 4'd5; sel = 2'b01; d_valid = 1'b1;
        tick();
        d = 4'd9;
        @(negedge clk);
        check("bp d_ready", d_ready, 1'b0);
        check("bp hold", q[7:4], 4'd5);
        tick();
        @(negedge clk);
        check("bp still held", q[7:4], 4'd5);
        tick();
        q_ready = 4'b0010;
        @(negedge clk);
        check("bp refill ready", d_ready, 1'b1);
        tick();
        q_ready = 4'b0000;
        d_valid = 1'b0;
        @(negedge clk);
        check("bp valid kept", q_valid[1], 1'b1);
        check("bp new word", q[7:4], 4'd9);

        // Independence: channel 0 stalled while channel 3 accepts.
        tick();
        d = 4'd6; sel = 2'b00; d_valid = 1'b1;
        tick();
        d = 4'hA; sel = 2'b11;
        @(negedge clk);
        check("indep ready", d_ready, 1'b1);
        tick();
        d_valid = 1'b0;
        @(negedge clk);
        check("indep q[3]", q[15:12], 4'hA);
        check("indep q[0]", q[3:0], 4'd6);
        check("indep q_valid", q_valid, 4'b1011);
        tick();
        q_ready = 4'hF;
        repeat (2) tick();

        // Streaming at full rate from a clean reset.
        do_reset(1);
        q_ready = 4'hF;
        for (int i = 0; i < 16; i++) begin
            d = W'(i); sel = SW'(i % N); d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        for (int k = 0; k < N; k++) check($sformatf("stream cnt[%0d]", k), cnt[k*CW +: CW], 8'd4);

        // Counter wrap on channel 0.
        tick();
        do_reset(1);
        q_ready = 4'hF;
        for (int i = 0; i < 256; i++) begin
            d = W'($urandom); sel = 2'b00; d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("wrap cnt[0]", cnt[7:0], 8'd0);

        // Randomized traffic with occasional resets.
        tick();
        for (int i = 0; i < 1500; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            d_valid = 1'($urandom);
            d       = W'($urandom);
            sel     = SW'($urandom);
            q_ready = N'($urandom);
            tick();
        end
        rst_n = 1'b1; d_valid = 1'b0;

        // Fill every channel, then reset mid-flight.
        q_ready = 4'hF;
        repeat (2) tick();
        q_ready = 4'h0;
        for (int i = 0; i < N; i++) begin
            d = W'(i + 7); sel = SW'(i); d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        @(negedge clk);
        check("fill q_valid", q_valid, 4'hF);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst q_valid", q_valid, 4'h0);
        check("midrst cnt", cnt, 32'h0);
        check("midrst busy", busy, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_demux_stream
`default_nettype wire
